// File: rtl/up_pkg.sv
`default_nettype none
// ============================================================================
// Module  : up_pkg
// Brief   : Opcodes, phase encoding and instruction-length helper for up_core.
// Revision: 1.0
// ============================================================================
package up_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ANDI = 4'h4;
    localparam logic [3:0] OP_ORI  = 4'h5;
    localparam logic [3:0] OP_XORI = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JC   = 4'hC;
    localparam logic [3:0] OP_JZ   = 4'hD;
    localparam logic [3:0] OP_CALL = 4'hE;
    localparam logic [3:0] OP_RET  = 4'hF;

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_e;

    // LD..CALL carry an address word after the opcode word.
    function automatic logic [1:0] instr_len(input logic [3:0] op);
        return ((op >= OP_LD) && (op <= OP_CALL)) ? 2'd2 : 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/up_core_param_if.sv
`default_nettype none
// ============================================================================
// Module  : up_core_param_if
// Brief   : Program ROM and data RAM bus between the core and its memories.
// Revision: 1.0
// ============================================================================
interface up_core_param_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 12
);
    localparam int INSTR_W = 4 + DATA_W;

    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;
    logic               ram_cs;
    logic               ram_we;

    modport master (
        output prog_addr,
        input  prog_data,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata,
        output ram_cs,
        output ram_we
    );

    modport slave (
        input  prog_addr,
        output prog_data,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata,
        input  ram_cs,
        input  ram_we
    );
endinterface
`default_nettype wire

// File: rtl/up_ret_stack.sv
`default_nettype none
// ============================================================================
// Module  : up_ret_stack
// Brief   : DEPTH x WIDTH LIFO holding CALL return addresses.
// Revision: 1.0
// ============================================================================
module up_ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]  r_sp;
    logic [WIDTH-1:0] r_mem [2**IDX_W];
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    // r_sp counts entries; the top of stack lives one below it.
    assign w_wr_idx = IDX_W'(r_sp);
    assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));
    assign full     = (r_sp == SP_W'(DEPTH));
    assign empty    = (r_sp == '0);
    assign dout     = r_mem[w_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/up_core_param.sv
`default_nettype none
// ============================================================================
// Module  : up_core_param
// Brief   : Two-phase accumulator core with CALL/RET return stack.
// Revision: 1.0
// ============================================================================
module up_core_param
    import up_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              ena,
    up_core_param_if.master        bus,
    input  wire logic [DATA_W-1:0] in_port,
    output logic      [DATA_W-1:0] out_port,
    output logic                   phase,
    output logic                   c_flag,
    output logic                   z_flag,
    output logic                   stack_err
);
    localparam int INSTR_W = 4 + DATA_W;
    localparam int TGT_W   = DATA_W + INSTR_W;

    generate
        if ((ADDR_W > TGT_W) || (ADDR_W < 1) || (STACK_DEPTH < 1)) begin : g_bad_params
            $error("up_core_param: illegal ADDR_W or STACK_DEPTH");
        end
    endgenerate

    phase_e            r_phase;
    logic [ADDR_W-1:0] r_pc;
    logic [3:0]        r_instr;
    logic [DATA_W-1:0] r_oprnd;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_out;
    logic              r_c;
    logic              r_z;
    logic              r_err;

    logic [TGT_W-1:0]  w_target_full;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [DATA_W:0]   w_add;
    logic [DATA_W:0]   w_sub;
    logic              w_exec;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_stack_top;

    // During Execute prog_data already shows the address word.
    assign w_target_full = {r_oprnd, bus.prog_data};
    assign w_target      = w_target_full[ADDR_W-1:0];
    assign w_pc_inc      = r_pc + ADDR_W'(1);
    assign w_add         = {1'b0, r_acc} + {1'b0, r_oprnd};
    assign w_sub         = {1'b0, r_acc} - {1'b0, r_oprnd};
    assign w_exec        = ena && (r_phase == PH_EXEC);
    assign w_push        = w_exec && (r_instr == OP_CALL) && !w_full;
    assign w_pop         = w_exec && (r_instr == OP_RET) && !w_empty;

    up_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_stack_top),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_FETCH;
            r_pc    <= '0;
            r_instr <= OP_NOP;
            r_oprnd <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_err   <= 1'b0;
        end else if (ena) begin
            if (r_phase == PH_FETCH) begin
                r_instr <= bus.prog_data[INSTR_W-1:DATA_W];
                r_oprnd <= bus.prog_data[DATA_W-1:0];
                r_pc    <= w_pc_inc;
                r_phase <= PH_EXEC;
            end else begin
                r_phase <= PH_FETCH;
                // Two-word instructions skip the address word unless they branch.
                if (instr_len(r_instr) == 2'd2) begin
                    r_pc <= w_pc_inc;
                end
                case (r_instr)
                    OP_LDI: begin
                        r_acc <= r_oprnd;
                        r_z   <= (r_oprnd == '0);
                    end
                    OP_ADDI: begin
                        r_acc <= w_add[DATA_W-1:0];
                        r_c   <= w_add[DATA_W];
                        r_z   <= (w_add[DATA_W-1:0] == '0);
                    end
                    OP_SUBI: begin
                        r_acc <= w_sub[DATA_W-1:0];
                        r_c   <= w_sub[DATA_W];
                        r_z   <= (w_sub[DATA_W-1:0] == '0);
                    end
                    OP_ANDI: begin
                        r_acc <= r_acc & r_oprnd;
                        r_c   <= 1'b0;
                        r_z   <= ((r_acc & r_oprnd) == '0);
                    end
                    OP_ORI: begin
                        r_acc <= r_acc | r_oprnd;
                        r_c   <= 1'b0;
                        r_z   <= ((r_acc | r_oprnd) == '0);
                    end
                    OP_XORI: begin
                        r_acc <= r_acc ^ r_oprnd;
                        r_c   <= 1'b0;
                        r_z   <= ((r_acc ^ r_oprnd) == '0);
                    end
                    OP_IN: begin
                        r_acc <= in_port;
                        r_z   <= (in_port == '0);
                    end
                    OP_OUT: r_out <= r_acc;
                    OP_LD: begin
                        r_acc <= bus.ram_rdata;
                        r_z   <= (bus.ram_rdata == '0);
                    end
                    OP_JMP: r_pc <= w_target;
                    OP_JC: begin
                        if (r_c) r_pc <= w_target;
                    end
                    OP_JZ: begin
                        if (r_z) r_pc <= w_target;
                    end
                    OP_CALL: begin
                        r_pc <= w_target;
                        if (w_full) r_err <= 1'b1;
                    end
                    OP_RET: begin
                        if (w_empty) r_err <= 1'b1;
                        else         r_pc  <= w_stack_top;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.prog_addr = r_pc;
    assign bus.ram_addr  = w_target;
    assign bus.ram_wdata = r_acc;
    assign bus.ram_cs    = w_exec && ((r_instr == OP_LD) || (r_instr == OP_ST));
    assign bus.ram_we    = w_exec && (r_instr == OP_ST);
    assign out_port      = r_out;
    assign phase         = r_phase;
    assign c_flag        = r_c;
    assign z_flag        = r_z;
    assign stack_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_up_core_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_up_core_param
// Brief   : Directed self-checking bench for up_core_param (DATA_W=4, ADDR_W=12).
// Revision: 1.0
// ============================================================================
module tb_up_core_param;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] in_port;
    logic [3:0] out_port;
    logic       phase;
    logic       c_flag;
    logic       z_flag;
    logic       stack_err;

    logic [7:0] rom [4096];
    logic [3:0] ram [4096];
    int         wr_count;
    int         n_tests;
    int         n_fail;
    int         wr_base;

    up_core_param_if #(.DATA_W(4), .ADDR_W(12)) bus ();

    up_core_param #(
        .DATA_W      (4),
        .ADDR_W      (12),
        .STACK_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .bus       (bus),
        .in_port   (in_port),
        .out_port  (out_port),
        .phase     (phase),
        .c_flag    (c_flag),
        .z_flag    (z_flag),
        .stack_err (stack_err)
    );

    assign bus.prog_data = rom[bus.prog_addr];
    assign bus.ram_rdata = ram[bus.ram_addr];

    initial wr_count = 0;

    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) begin
            ram[bus.ram_addr] <= bus.ram_wdata;
            wr_count          <= wr_count + 1;
        end
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ena   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        ena      = 1'b1;
        in_port  = 4'h0;
        n_tests  = 0;
        n_fail   = 0;

        // LDI 5; ADDI C; OUT
        clear_rom();
        rom[0] = 8'h15; rom[1] = 8'h2C; rom[2] = 8'h80;
        do_reset();
        chk("rst_pc",     32'(bus.prog_addr), 32'h000);
        chk("rst_phase",  32'(phase),         32'h0);
        chk("rst_out",    32'(out_port),      32'h0);
        chk("rst_c",      32'(c_flag),        32'h0);
        chk("rst_z",      32'(z_flag),        32'h0);
        chk("rst_err",    32'(stack_err),     32'h0);
        chk("rst_cs",     32'(bus.ram_cs),    32'h0);
        step(6);
        chk("add_out",    32'(out_port),      32'h1);
        chk("add_c",      32'(c_flag),        32'h1);
        chk("add_z",      32'(z_flag),        32'h0);
        chk("add_pc",     32'(bus.prog_addr), 32'h003);

        // SUBI borrow, SUBI to zero, JZ taken
        clear_rom();
        rom[0] = 8'h12; rom[1] = 8'h33; rom[2] = 8'h80;
        rom[3] = 8'h13; rom[4] = 8'h33; rom[5] = 8'h80;
        rom[6] = 8'hD0; rom[7] = 8'h40;
        do_reset();
        step(6);
        chk("sub_brw_out", 32'(out_port), 32'hF);
        chk("sub_brw_c",   32'(c_flag),   32'h1);
        chk("sub_brw_z",   32'(z_flag),   32'h0);
        step(6);
        chk("sub_zero_out", 32'(out_port), 32'h0);
        chk("sub_zero_c",   32'(c_flag),   32'h0);
        chk("sub_zero_z",   32'(z_flag),   32'h1);
        step(2);
        chk("jz_pc", 32'(bus.prog_addr), 32'h040);

        // LDI 9; ST 0x123; LDI 0; LD 0x123; OUT
        clear_rom();
        rom[0] = 8'h19; rom[1] = 8'hA1; rom[2] = 8'h23;
        rom[3] = 8'h10; rom[4] = 8'h91; rom[5] = 8'h23; rom[6] = 8'h80;
        do_reset();
        wr_base = wr_count;
        step(3);
        chk("st_cs",    32'(bus.ram_cs),    32'h1);
        chk("st_we",    32'(bus.ram_we),    32'h1);
        chk("st_addr",  32'(bus.ram_addr),  32'h123);
        chk("st_wdata", 32'(bus.ram_wdata), 32'h9);
        step(1);
        chk("st_we_off", 32'(bus.ram_we),      32'h0);
        chk("st_count",  32'(wr_count - wr_base), 32'd1);
        chk("st_mem",    32'(ram[12'h123]),    32'h9);
        step(3);
        chk("ld_cs", 32'(bus.ram_cs), 32'h1);
        chk("ld_we", 32'(bus.ram_we), 32'h0);
        step(3);
        chk("ld_out",   32'(out_port),           32'h9);
        chk("ld_count", 32'(wr_count - wr_base), 32'd1);

        // CALL 0x200 from 0x010, RET back to 0x012
        clear_rom();
        rom[12'h000] = 8'hB0; rom[12'h001] = 8'h10;
        rom[12'h010] = 8'hE2; rom[12'h011] = 8'h00;
        rom[12'h200] = 8'hF0;
        do_reset();
        step(2);
        chk("jmp_pc", 32'(bus.prog_addr), 32'h010);
        step(2);
        chk("call_pc", 32'(bus.prog_addr), 32'h200);
        step(2);
        chk("ret_pc",  32'(bus.prog_addr), 32'h012);
        chk("ret_err", 32'(stack_err),     32'h0);

        // Five nested CALLs overflow a 4-deep stack
        clear_rom();
        rom[12'h000] = 8'hE1; rom[12'h001] = 8'h00;
        rom[12'h100] = 8'hE2; rom[12'h101] = 8'h00;
        rom[12'h200] = 8'hE3; rom[12'h201] = 8'h00;
        rom[12'h300] = 8'hE4; rom[12'h301] = 8'h00;
        rom[12'h400] = 8'hE5; rom[12'h401] = 8'h00;
        rom[12'h500] = 8'hF0;
        do_reset();
        step(8);
        chk("nest4_pc",  32'(bus.prog_addr), 32'h400);
        chk("nest4_err", 32'(stack_err),     32'h0);
        step(2);
        chk("nest5_pc",  32'(bus.prog_addr), 32'h500);
        chk("nest5_err", 32'(stack_err),     32'h1);
        step(2);
        chk("ovf_ret_pc", 32'(bus.prog_addr), 32'h302);

        // RET on empty stack, then IN/OUT; error stays sticky
        clear_rom();
        rom[0] = 8'hF0; rom[1] = 8'h70; rom[2] = 8'h80;
        in_port = 4'hA;
        do_reset();
        step(2);
        chk("uflow_pc",  32'(bus.prog_addr), 32'h001);
        chk("uflow_err", 32'(stack_err),     32'h1);
        step(4);
        chk("in_out",     32'(out_port),  32'hA);
        chk("in_z",       32'(z_flag),    32'h0);
        chk("err_sticky", 32'(stack_err), 32'h1);

        // PC wraps from 0xFFF to 0
        clear_rom();
        rom[12'h000] = 8'hBF; rom[12'h001] = 8'hFF; rom[12'hFFF] = 8'h15;
        do_reset();
        step(2);
        chk("wrap_jmp_pc", 32'(bus.prog_addr), 32'hFFF);
        step(1);
        chk("wrap_pc",     32'(bus.prog_addr), 32'h000);

        // ena stall in ST Execute, then async reset during a second ST
        clear_rom();
        rom[0] = 8'h19; rom[1] = 8'hA1; rom[2] = 8'h23;
        rom[3] = 8'h80; rom[4] = 8'hA1; rom[5] = 8'h45;
        do_reset();
        wr_base = wr_count;
        step(3);
        ena = 1'b0;
        #1;
        chk("hold_cs", 32'(bus.ram_cs), 32'h0);
        chk("hold_we", 32'(bus.ram_we), 32'h0);
        step(3);
        chk("hold_phase", 32'(phase),              32'h1);
        chk("hold_pc",    32'(bus.prog_addr),      32'h002);
        chk("hold_count", 32'(wr_count - wr_base), 32'd0);
        ena = 1'b1;
        #1;
        chk("resume_we", 32'(bus.ram_we), 32'h1);
        step(1);
        chk("resume_count", 32'(wr_count - wr_base), 32'd1);
        chk("resume_pc",    32'(bus.prog_addr),      32'h003);
        step(2);
        chk("pre_rst_out", 32'(out_port), 32'h9);
        step(1);
        chk("pre_rst_we", 32'(bus.ram_we), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc",    32'(bus.prog_addr), 32'h000);
        chk("arst_phase", 32'(phase),         32'h0);
        chk("arst_out",   32'(out_port),      32'h0);
        chk("arst_cs",    32'(bus.ram_cs),    32'h0);
        chk("arst_we",    32'(bus.ram_we),    32'h0);
        step(1);
        chk("arst_count", 32'(wr_count - wr_base), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
